llr_loader: RTL and testbench



---
 rtl/ldpc_pkg.sv | 26 ++
 rtl/llr_bank.sv | 31 +++
 rtl/llr_loader.sv | 96 +++++++++
 tb/tb_llr_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ldpc_pkg : shared LDPC decoder sizing, LLR limits and saturation helper  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ldpc_pkg;

  localparam int DATA_W  = 8;
  localparam int R       = 5;
  localparam int D       = 8;
  localparam int N       = R * D;
  localparam int SAT_W   = 32;
  localparam int LLR_MAX = 2 ** (DATA_W - 1) - 1;
  localparam int LLR_MIN = -LLR_MAX;

  typedef logic [DATA_W-1:0] llr_t;

  // Symmetric clamp: the most negative code never appears downstream.
  function automatic llr_t sat_llr(input logic signed [SAT_W-1:0] x);
    if (x > LLR_MAX) return llr_t'(LLR_MAX);
    if (x < LLR_MIN) return llr_t'(LLR_MIN);
    return x[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/llr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llr_bank : DEPTH x WORD_W register bank, indexed write, parallel read    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module llr_bank
  import ldpc_pkg::*;
#(
  parameter int WORD_W = DATA_W,
  parameter int DEPTH  = N,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [WORD_W-1:0]       i_data,
  output logic [WORD_W*DEPTH-1:0] o_bus
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clk) begin
      if (i_we && (i_idx == IDX_W'(i))) r_word <= i_data;
    end

    assign o_bus[i*WORD_W +: WORD_W] = r_word;
  end

endmodule
`default_nettype wire

// File: rtl/llr_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llr_loader : serial channel-LLR intake, saturation, ping-pong framing    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module llr_loader
  import ldpc_pkg::*;
#(
  parameter int IN_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     in_llr,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  output logic [DATA_W*N-1:0] frame_llr,
  output logic                frame_valid,
  input  logic                frame_ack,
  output logic                frame_err
);

  localparam int               CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0]    r_wr_cnt;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [1:0]          r_full;
  logic                r_err;

  logic                w_acc;
  logic                w_resync;
  logic                w_last;
  logic                w_ack;
  logic [CNT_W-1:0]    w_idx;
  logic [1:0]          w_full_nxt;
  logic [SAT_W-1:0]    w_sample_ext;
  llr_t                w_sat;
  logic [DATA_W*N-1:0] w_bus [2];

  assign in_ready = !rst && !r_full[r_wr_bank];
  assign w_acc    = in_valid && in_ready;
  assign w_resync = w_acc && in_sof && (r_wr_cnt != '0);
  assign w_idx    = w_resync ? '0 : r_wr_cnt;
  assign w_last   = w_acc && (w_idx == C_LAST);
  assign w_ack    = r_full[r_rd_bank] && frame_ack;

  assign w_sample_ext = {{(SAT_W - IN_W){in_llr[IN_W-1]}}, in_llr};
  assign w_sat        = sat_llr(w_sample_ext);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    llr_bank #(
      .WORD_W (DATA_W),
      .DEPTH  (N),
      .IDX_W  (CNT_W)
    ) u_bank (
      .clk    (clk),
      .i_we   (w_acc && (r_wr_bank == 1'(b))),
      .i_idx  (w_idx),
      .i_data (w_sat),
      .o_bus  (w_bus[b])
    );
  end

  // Completion and ack never target the same bank: a full write bank blocks accepts.
  always_comb begin
    w_full_nxt = r_full;
    if (w_ack)  w_full_nxt[r_rd_bank] = 1'b0;
    if (w_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      r_err  <= w_resync;
      r_full <= w_full_nxt;
      if (w_acc) begin
        r_wr_cnt <= w_last ? '0 : w_idx + 1'b1;
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_ack) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign frame_valid = r_full[r_rd_bank];
  assign frame_llr   = r_rd_bank ? w_bus[1] : w_bus[0];
  assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_llr_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_llr_loader : random + directed stimulus against a frame-queue model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_llr_loader;
  import ldpc_pkg::*;

  localparam int IN_W = 10;

  typedef logic [DATA_W*N-1:0] frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] in_llr = '0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic            frame_ack = 1'b0;
  logic            in_ready;
  frame_t          frame_llr;
  logic            frame_valid;
  logic            frame_err;

  int n_checks = 0;
  int n_err    = 0;
  int err_pulses = 0;
  bit rnd_done = 1'b0;

  llr_loader #(.IN_W(IN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_llr      (in_llr),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .frame_llr   (frame_llr),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Model: completed frames form a FIFO of depth two, plus one partial frame.
  frame_t      mq[$];
  byte unsigned cur[N];
  int          cnt = 0;
  bit          m_err = 1'b0;
  frame_t      m_f;

  function automatic int sat_model(input logic [IN_W-1:0] x);
    int v;
    int lim;
    v   = int'($signed(x));
    lim = (1 << (DATA_W - 1)) - 1;
    if (v > lim)  v = lim;
    if (v < -lim) v = -lim;
    return v;
  endfunction

  initial forever begin
    bit ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      cnt   = 0;
      m_err = 1'b0;
    end else begin
      ready = (mq.size() < 2);
      m_err = 1'b0;
      if (frame_ack && mq.size() > 0) mq.delete(0);
      if (in_valid && ready) begin
        if (in_sof && cnt != 0) begin
          m_err = 1'b1;
          cnt   = 0;
        end
        cur[cnt] = 8'(sat_model(in_llr));
        cnt++;
        if (cnt == N) begin
          for (int n = 0; n < N; n++) m_f[n*DATA_W +: DATA_W] = cur[n];
          mq.push_back(m_f);
          cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input frame_t act, input frame_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      for (int n = 0; n < N; n++) begin
        if (act[n*DATA_W +: DATA_W] !== exp[n*DATA_W +: DATA_W]) begin
          $display("FAIL frame_llr: sample %0d got %h expected %h at %0t", n,
                   act[n*DATA_W +: DATA_W], exp[n*DATA_W +: DATA_W], $time);
          break;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, !rst && (mq.size() < 2));
    chk("frame_valid", frame_valid, mq.size() > 0);
    chk("frame_err", frame_err, m_err);
    if (frame_err === 1'b1) err_pulses++;
    if (mq.size() > 0) chk_frame(frame_llr, mq[0]);
  end

  // Entered and left at posedge+1; holds the beat until it is accepted.
  task automatic send(input int v, input bit sof, input bit ack);
    int w;
    in_llr   = IN_W'(v);
    in_sof   = sof;
    in_valid = 1'b1;
    if (ack) frame_ack = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (ack) frame_ack = 1'b0;
  endtask

  task automatic send_ramp(input int start, input int n, input bit sof1, input bit ack_last);
    for (int i = 0; i < n; i++) send(start + i, sof1 && (i == 0), ack_last && (i == n - 1));
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  int sv[6];
  logic [7:0] se[6];
  int e0;

  initial begin
    sv = '{300, -300, -128, -127, 127, -1};
    se = '{8'h7F, 8'h81, 8'h81, 8'h81, 8'h7F, 8'hFF};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", frame_valid, 1'b0);
    rst = 1'b0;

    // Ramp frame
    e0 = err_pulses;
    send_ramp(0, N, 1'b1, 1'b0);
    chk("ramp_valid", frame_valid, 1'b1);
    for (int n = 0; n < N; n++) chk8("ramp_byte", frame_llr[n*8 +: 8], 8'(n));
    ack_pulse();
    chk("ramp_valid_drop", frame_valid, 1'b0);
    chki("ramp_err_pulses", err_pulses - e0, 0);

    // Saturation
    for (int i = 0; i < 6; i++) send(sv[i], i == 0, 1'b0);
    send_ramp(0, N - 6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) chk8("sat_byte", frame_llr[i*8 +: 8], se[i]);
    ack_pulse();

    // Ping-pong backpressure
    send_ramp(10, N, 1'b1, 1'b0);
    send_ramp(50, N, 1'b1, 1'b0);
    chk("pp_ready_low", in_ready, 1'b0);
    fork
      send_ramp(80, N, 1'b1, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("pp_stall", in_ready, 1'b0);
        ack_pulse();
        chk("pp_ready_back", in_ready, 1'b1);
      end
    join
    ack_pulse();
    chk8("pp_f3_first", frame_llr[7:0], 8'd80);
    chk8("pp_f3_last", frame_llr[(N-1)*8 +: 8], 8'd119);
    ack_pulse();

    // Completion and ack on the same edge
    send_ramp(1, N, 1'b1, 1'b0);
    send_ramp(60, N, 1'b1, 1'b1);
    chk("sim_valid", frame_valid, 1'b1);
    chk8("sim_first", frame_llr[7:0], 8'd60);
    chk8("sim_last", frame_llr[(N-1)*8 +: 8], 8'd99);
    ack_pulse();

    // SOF resync
    e0 = err_pulses;
    send_ramp(5, 17, 1'b1, 1'b0);
    send(32'h55, 1'b1, 1'b0);
    send_ramp(20, N - 1, 1'b0, 1'b0);
    @(negedge clk);
    chki("sof_err_pulses", err_pulses - e0, 1);
    chk8("sof_first", frame_llr[7:0], 8'h55);
    chk8("sof_second", frame_llr[15:8], 8'd20);
    @(posedge clk);
    #1;
    ack_pulse();

    // Reset mid-frame
    send_ramp(7, N, 1'b1, 1'b0);
    send_ramp(30, 20, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", frame_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    send_ramp(40, N, 1'b0, 1'b0);
    chk8("rst_mid_first", frame_llr[7:0], 8'd40);
    chk8("rst_mid_last", frame_llr[(N-1)*8 +: 8], 8'd79);
    ack_pulse();

    // Random traffic with random acks and occasional resyncs
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(int'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0, 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          frame_ack = ($urandom_range(0, 3) == 0);
          @(posedge clk);
          #1;
        end
        frame_ack = 1'b0;
      end
    join
    repeat (3) ack_pulse();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
